synaptic_current_integrator: RTL and testbench
==============================================

# synaptic_current_integrator

Upstream stage of the Izhikevich neuron core: collects weighted incoming spike events, integrates them into a decaying synaptic current, and once per simulation timestep presents the new input current `i` together with a one-cycle `apply` strobe. All arithmetic is signed fixed point, N total bits with Q fractional bits, saturating. The `i_out`/`apply` outputs connect directly to the core's `i`/`apply` inputs.

## Interface
- `N`, 32, total word width, signed two's complement
- `Q`, 16, fractional bits (1.0 = 0x00010000 at defaults)
- `DEPTH`, 8, event FIFO depth (power of two, ≥2)
- `DECAY_SHIFT`, 3, per-step decay: acc ← acc − (acc >>> DECAY_SHIFT)

Ports:
- `clk` in 1, rising-edge clock
- `rst` in 1, synchronous, active-high
- `ev_valid` in 1, event offered
- `ev_weight` in N, signed event weight
- `ev_ready` out 1, FIFO can accept (= !full, forced 0 while rst)
- `step` in 1, timestep request, sampled each edge
- `i_bias` in N, signed constant bias current, sampled in APPLY
- `i_out` out N, registered current to neuron core
- `apply` out 1, one-cycle strobe, `i_out` valid
- `busy` out 1, high in any state other than IDLE
- `overflow` out 1, sticky saturation flag

## Operation
- Event push: handshake completes on an edge with `ev_valid & ev_ready`. Pushes are accepted in every state. No push when full, even if a pop occurs in the same cycle.
- States: IDLE, DRAIN, DECAY, APPLY.
- IDLE: on `step`=1, snapshot n = FIFO occupancy. Next state is DRAIN if n>0, else DECAY.
- DRAIN: pop one entry per cycle, acc ← sat(acc + weight). After exactly n pops, go to DECAY. Events pushed after the snapshot stay in the FIFO for the next step.
- DECAY: acc ← acc − (acc >>> DECAY_SHIFT), using an arithmetic shift. This cannot overflow. Next state is APPLY.
- APPLY: i_out ← sat(acc + i_bias) and apply ← 1 at the same edge, then return to IDLE. acc itself does not include the bias.
- `step` outside IDLE is ignored. It is not queued.
- Saturation bounds: 0x7FFFFFFF / 0x80000000 (N-bit extremes). Any clamp in DRAIN or APPLY sets `overflow`. Only rst clears it.
- `i_out` holds its value between apply strobes.

## Timing
- Reset values: acc=0, i_out=0, apply=0, busy=0, overflow=0, FIFO empty, state IDLE.
- `ev_ready` is 0 during rst and 1 in the first cycle after rst.
- Latency: with step sampled at edge E and n snapshotted events, `apply` is high for exactly the cycle following edge E+n+2. It is low on all other cycles.
- Minimum step period is n+3 cycles.
- `busy` rises at edge E and falls at the edge that ends the APPLY cycle. A step offered in that same next cycle is accepted.
- `rst` mid-operation: everything returns to reset values at that edge, FIFO contents are discarded, and no `apply` is produced for the aborted step.
- FIFO wrap-around of pointers must be transparent, including a full→empty drain.

## Test plan
1. Reset: assert rst 2 cycles, then release. Required: i_out=0, apply=0, busy=0, overflow=0, ev_ready=1.
2. Basic step:
   - Stimulus: push 0x00010000 and 0x00008000, i_bias=0, pulse step.
   - Required: apply high exactly 4 edges after step; i_out=0x00015000 (1.5→1.3125).
   - Follow-on: a second step with no events gives apply at +2 and i_out=0x00012600.
3. Negative weight and bias:
   - Stimulus: from reset, push 0xFFFF0000 (−1.0), i_bias=0x00020000, step.
   - Required: i_out=0x00012000 (−0.875 + 2.0); overflow stays 0.
4. Saturation:
   - Stimulus: push 0x7FFF0000 twice, step.
   - Required: acc clamps to 0x7FFFFFFF; i_out=0x70000000; overflow=1.
   - Follow-on: next step with i_bias=0x7FFFFFFF gives i_out=0x7FFFFFFF.
5. FIFO full and snapshot:
   - Stimulus: push 8 events of 0x00001000; hold a 9th valid.
   - Required: ev_ready=0 with the 9th held; step drains exactly 8; the 9th is accepted during DRAIN but is not included (i_out=0x00007000); the next step includes it.
   - Also: a step pulsed while busy produces no extra apply.
6. Reset mid-DRAIN:
   - Stimulus: 4 events queued, step, assert rst on the 2nd DRAIN cycle.
   - Required: no apply pulse; i_out=0; FIFO empty; a subsequent step with no events yields i_out=0.

Source files
------------

// File: rtl/synaptic_current_integrator.sv
// synaptic_current_integrator: buffers weighted spike events, integrates them into a decaying current and strobes it out once per step
module synaptic_current_integrator #(
  parameter int N = 32,
  parameter int Q = 16,
  parameter int DEPTH = 8,
  parameter int DECAY_SHIFT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ev_valid,
  input  logic [N-1:0] ev_weight,
  output logic         ev_ready,
  input  logic         step,
  input  logic [N-1:0] i_bias,
  output logic [N-1:0] i_out,
  output logic         apply,
  output logic         busy,
  output logic         overflow
);
  localparam int AW = $clog2(DEPTH);
  if (Q >= N || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("synaptic_current_integrator: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, DRAIN, DECAY, APPLY} state_t;
  state_t state;
  logic [N-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, rem, count;
  logic signed [N-1:0] acc;
  logic [N:0] drain_sum, apply_sum;
  logic full, push;
  // Result bit N flags a clamp; bits N-1:0 hold the saturated sum.
  function automatic logic [N:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {a[N-1], a} + {b[N-1], b};
    return (s[N] != s[N-1]) ? {1'b1, s[N], {(N-1){~s[N]}}} : {1'b0, s[N-1:0]};
  endfunction
  assign count = wr_ptr - rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign ev_ready = !full && !rst;
  assign push = ev_valid && ev_ready;
  assign busy = state != IDLE;
  assign drain_sum = sat_add(acc, mem[rd_ptr[AW-1:0]]);
  assign apply_sum = sat_add(acc, i_bias);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= ev_weight;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rem <= '0;
      acc <= '0;
      i_out <= '0;
      apply <= 1'b0;
      overflow <= 1'b0;
    end else begin
      apply <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE: if (step) begin
          rem <= count;
          state <= (count != '0) ? DRAIN : DECAY;
        end
        DRAIN: begin
          acc <= drain_sum[N-1:0];
          overflow <= overflow | drain_sum[N];
          rd_ptr <= rd_ptr + 1'b1;
          rem <= rem - 1'b1;
          if (rem == (AW+1)'(1)) state <= DECAY;
        end
        DECAY: begin
          acc <= acc - (acc >>> DECAY_SHIFT);
          state <= APPLY;
        end
        APPLY: begin
          i_out <= apply_sum[N-1:0];
          overflow <= overflow | apply_sum[N];
          apply <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_synaptic_current_integrator.sv
// tb_synaptic_current_integrator: directed stimulus with a queued scoreboard checked by an independent apply monitor
module tb_synaptic_current_integrator;
  logic clk = 0, rst = 0, ev_valid = 0, step = 0;
  logic [31:0] ev_weight = '0, i_bias = '0;
  logic ev_ready, apply, busy, overflow;
  logic [31:0] i_out;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {logic [31:0] v; int c;} exp_t;
  exp_t sb[$];
  exp_t e;

  synaptic_current_integrator dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_weight(ev_weight), .ev_ready(ev_ready),
    .step(step), .i_bias(i_bias), .i_out(i_out), .apply(apply), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every apply strobe must match the oldest expectation in value and cycle.
  always @(negedge clk)
    if (apply) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_apply: i_out=0x%h at cycle %0d, none expected", i_out, cyc);
      end else begin
        e = sb.pop_front();
        chk("apply_cycle", cyc, e.c);
        chk("i_out", i_out, e.v);
      end
    end

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    ev_valid = 0;
    step = 0;
    i_bias = '0;
    #1 chk("ev_ready_in_rst", {31'b0, ev_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_i_out", i_out, 32'd0);
    chk("rst_apply", {31'b0, apply}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_ev_ready", {31'b0, ev_ready}, 32'd1);
  endtask

  task automatic push(input logic [31:0] w);
    ev_valid = 1;
    ev_weight = w;
    @(negedge clk);
    ev_valid = 0;
  endtask

  task automatic do_step(input int n, input logic [31:0] exp);
    sb.push_back('{exp, cyc + 1 + n + 2});
    step = 1;
    @(negedge clk);
    step = 0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy) break;
    end
    if (k == 60) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: timeout with %0d applies pending, busy=%0b", sb.size(), busy);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    push(32'h0001_0000);
    push(32'h0000_8000);
    do_step(2, 32'h0001_5000);
    wait_idle();
    do_step(0, 32'h0001_2600);
    wait_idle();

    do_reset();
    push(32'hFFFF_0000);
    i_bias = 32'h0002_0000;
    do_step(1, 32'h0001_2000);
    wait_idle();
    chk("neg_overflow", {31'b0, overflow}, 32'd0);

    do_reset();
    push(32'h7FFF_0000);
    push(32'h7FFF_0000);
    do_step(2, 32'h7000_0000);
    wait_idle();
    chk("sat_overflow", {31'b0, overflow}, 32'd1);
    i_bias = 32'h7FFF_FFFF;
    do_step(0, 32'h7FFF_FFFF);
    wait_idle();

    do_reset();
    for (int i = 0; i < 8; i++) push(32'h0000_1000);
    ev_valid = 1;
    ev_weight = 32'h0000_8000;
    #1 chk("full_ev_ready", {31'b0, ev_ready}, 32'd0);
    do_step(8, 32'h0000_7000);
    for (int k = 0; k < 20 && !ev_ready; k++) @(negedge clk);
    chk("ready_in_drain", {31'b0, ev_ready}, 32'd1);
    @(negedge clk);
    ev_valid = 0;
    step = 1;
    @(negedge clk);
    step = 0;
    wait_idle();
    do_step(1, 32'h0000_D200);
    wait_idle();

    do_reset();
    for (int i = 0; i < 4; i++) push(32'h0001_0000);
    step = 1;
    @(negedge clk);
    step = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_i_out", i_out, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ev_ready", {31'b0, ev_ready}, 32'd1);
    repeat (10) @(negedge clk);
    do_step(0, 32'd0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
